// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported backing memory between the instruction-fetch port and the
// load/store port: range checks, data-priority arbitration with a streak limit, and a req/ack handshake with a timeout.
module mem_arbiter #(
    parameter logic [31:0] INSTR_LO   = 32'h0000_0000,
    parameter logic [31:0] INSTR_HI   = 32'h0000_FFFF,
    parameter logic [31:0] DATA_LO    = 32'h0001_0000,
    parameter logic [31:0] DATA_HI    = 32'h0001_FFFF,
    parameter int unsigned STREAK_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_rd,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr,
    output logic        wait_instr,
    output logic        instr_segv,
    input  logic        rd,
    input  logic        wd,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    output logic [31:0] data,
    output logic        wait_data,
    output logic        data_segv,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned SW = (STREAK_MAX < 1) ? 1 : $clog2(STREAK_MAX + 1);
    localparam logic [31:0] INSTR_SPAN = INSTR_HI - INSTR_LO;
    localparam logic [31:0] DATA_SPAN  = DATA_HI - DATA_LO;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {OWN_INSTR, OWN_DATA} owner_t;

    state_t        state;
    owner_t        owner;
    logic [SW-1:0] streak;
    logic [7:0]    tcount;

    logic instr_ok;
    logic data_ok;
    logic data_pend;
    logic pick_data;

    // Offset-from-base compare: one unsigned test per window, valid for any LO <= HI.
    always_comb begin
        instr_ok  = (instr_addr - INSTR_LO) <= INSTR_SPAN;
        data_ok   = ((data_addr - DATA_LO) <= DATA_SPAN) && !(rd && wd);
        data_pend = rd || wd;
        pick_data = data_pend && (!instr_rd || (streak != SW'(STREAK_MAX)));
    end

    assign wait_instr = instr_rd  && !((state == DONE) && (owner == OWN_INSTR));
    assign wait_data  = data_pend && !((state == DONE) && (owner == OWN_DATA));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_INSTR;
            streak     <= '0;
            tcount     <= '0;
            instr      <= '0;
            instr_segv <= 1'b0;
            data       <= '0;
            data_segv  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!instr_rd) streak <= '0;
                    if (pick_data) begin
                        owner     <= OWN_DATA;
                        mem_addr  <= data_addr;
                        mem_wdata <= data_in;
                        if (instr_rd) streak <= streak + 1'b1;
                        if (data_ok) begin
                            state  <= BUSY;
                            mem_rd <= rd;
                            mem_wr <= wd;
                        end else begin
                            state     <= DONE;
                            data      <= '0;
                            data_segv <= 1'b1;
                        end
                    end else if (instr_rd) begin
                        owner     <= OWN_INSTR;
                        mem_addr  <= instr_addr;
                        mem_wdata <= '0;
                        streak    <= '0;
                        if (instr_ok) begin
                            state  <= BUSY;
                            mem_rd <= 1'b1;
                        end else begin
                            state      <= DONE;
                            instr      <= '0;
                            instr_segv <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack) begin
                        state  <= DONE;
                        tcount <= '0;
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        // Results land on entry to DONE so they are valid while wait is low.
                        if (owner == OWN_DATA) begin
                            data      <= mem_wr ? '0 : mem_rdata;
                            data_segv <= 1'b0;
                        end else begin
                            instr      <= mem_rdata;
                            instr_segv <= 1'b0;
                        end
                    end else if (tcount == 8'(TIMEOUT - 1)) begin
                        state  <= DONE;
                        tcount <= '0;
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                        if (owner == OWN_DATA) begin
                            data      <= '0;
                            data_segv <= 1'b1;
                        end else begin
                            instr      <= '0;
                            instr_segv <= 1'b1;
                        end
                    end else begin
                        tcount <= tcount + 8'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
